// File: rtl/imm_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : imm_pkg
//  Description : Shared immediate-format definitions for decode, control and
//                the immediate generator.
//                - imm_src_t   : 3-bit format select; codes 00..11 keep the
//                                meaning of the legacy 2-bit select.
//                - INSTR_WIDTH : raw instruction word width.
//  Revision    : 1.0  initial release
// ============================================================================
package imm_pkg;

  localparam int INSTR_WIDTH = 32;

  typedef enum logic [2:0] {
    IMM_I     = 3'b000,
    IMM_S     = 3'b001,
    IMM_B     = 3'b010,
    IMM_U     = 3'b011,
    IMM_J     = 3'b100,
    IMM_SHAMT = 3'b101,
    IMM_ZIMM  = 3'b110,
    IMM_ILL   = 3'b111
  } imm_src_t;

endpackage : imm_pkg
`default_nettype wire

// File: rtl/imm_extract.sv
`default_nettype none
// ============================================================================
//  Module      : imm_extract
//  Description : Combinational immediate extraction and extension for the
//                RV32I/RV64I formats plus shift amount and CSR zimm.
//  Ports       : instr   in  INSTR_WIDTH  raw instruction word
//                ImmSrc  in  3            format select (imm_src_t encoding)
//                ImmOp   out DATA_WIDTH   extended immediate
//                illegal out 1            ImmSrc was the reserved code 3'b111
//  Revision    : 1.0  initial release
// ============================================================================
module imm_extract
  import imm_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [INSTR_WIDTH-1:0] instr,
  input  logic [2:0]             ImmSrc,
  output logic [DATA_WIDTH-1:0]  ImmOp,
  output logic                   illegal
);

  // Only 32- and 64-bit datapaths are meaningful; stop elaboration otherwise.
  if (!(DATA_WIDTH == 32 || DATA_WIDTH == 64)) begin : g_width_check
    $error("imm_extract: DATA_WIDTH must be 32 or 64");
  end

  // Every format is built at 64 bits and then truncated. Sign extension to 64
  // followed by truncation gives the correct 32-bit result too, so U-type
  // needs no special case for a zero-width replication.
  logic [63:0] w_imm64;
  logic        w_sign;
  logic        w_shamt_msb;

  assign w_sign      = instr[31];
  // RV64 shift amounts are 6 bits; on RV32 bit 25 is not part of shamt.
  assign w_shamt_msb = (DATA_WIDTH == 64) ? instr[25] : 1'b0;

  always_comb begin
    w_imm64 = '0;
    illegal = 1'b0;
    case (imm_src_t'(ImmSrc))
      IMM_I:     w_imm64 = {{52{w_sign}}, instr[31:20]};
      IMM_S:     w_imm64 = {{52{w_sign}}, instr[31:25], instr[11:7]};
      IMM_B:     w_imm64 = {{52{w_sign}}, instr[7], instr[30:25], instr[11:8], 1'b0};
      IMM_U:     w_imm64 = {{32{w_sign}}, instr[31:12], 12'b0};
      IMM_J:     w_imm64 = {{44{w_sign}}, instr[19:12], instr[20], instr[30:21], 1'b0};
      IMM_SHAMT: w_imm64 = {58'b0, w_shamt_msb, instr[24:20]};
      IMM_ZIMM:  w_imm64 = {59'b0, instr[19:15]};
      default: begin
        // Reserved code: flag it rather than alias it onto a real format.
        w_imm64 = '0;
        illegal = 1'b1;
      end
    endcase
  end

  assign ImmOp = w_imm64[DATA_WIDTH-1:0];

  // Opcode bits never feed an immediate; the upper half is dropped for RV32.
  logic w_unused;
  assign w_unused = ^{instr[6:0], w_imm64};

endmodule : imm_extract
`default_nettype wire

// File: rtl/imm_gen_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : imm_gen_pipe
//  Description : Registered, valid/ready flow-controlled immediate generator
//                sitting between decode and execute. A 2-entry elastic buffer
//                (output register + skid register) gives 1-cycle latency and
//                full throughput while keeping in_ready purely registered.
//  Ports       : clk        in   1           rising-edge clock
//                rst_n      in   1           asynchronous active-low reset
//                in_valid   in   1           instr/ImmSrc valid
//                in_ready   out  1           input accepted this cycle
//                instr      in   32          raw instruction word
//                ImmSrc     in   3           format select
//                out_valid  out  1           ImmOp/illegal valid
//                out_ready  in   1           consumer accepts output
//                ImmOp      out  DATA_WIDTH  extended immediate
//                illegal    out  1           ImmSrc was 3'b111
//  Revision    : 1.0  initial release
// ============================================================================
module imm_gen_pipe
  import imm_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [INSTR_WIDTH-1:0] instr,
  input  logic [2:0]             ImmSrc,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [DATA_WIDTH-1:0]  ImmOp,
  output logic                   illegal
);

  logic [DATA_WIDTH-1:0] w_ext_imm;
  logic                  w_ext_ill;

  imm_extract #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_extract (
    .instr   (instr),
    .ImmSrc  (ImmSrc),
    .ImmOp   (w_ext_imm),
    .illegal (w_ext_ill)
  );

  logic                  r_out_valid;
  logic [DATA_WIDTH-1:0] r_out_imm;
  logic                  r_out_ill;
  logic                  r_skid_valid;
  logic [DATA_WIDTH-1:0] r_skid_imm;
  logic                  r_skid_ill;

  logic w_accept;
  logic w_out_free;

  // The skid register is empty exactly when there is room for one more item,
  // so in_ready comes straight from a flop with no path from out_ready.
  assign in_ready   = ~r_skid_valid;
  assign w_accept   = in_valid & in_ready;
  // The output register may be (re)loaded this edge.
  assign w_out_free = ~r_out_valid | out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid  <= 1'b0;
      r_out_imm    <= '0;
      r_out_ill    <= 1'b0;
      r_skid_valid <= 1'b0;
      r_skid_imm   <= '0;
      r_skid_ill   <= 1'b0;
    end else if (w_out_free) begin
      if (r_skid_valid) begin
        // FULL -> ONE: the older skid item goes out first. in_ready was low,
        // so no new item can arrive on this edge.
        r_out_valid  <= 1'b1;
        r_out_imm    <= r_skid_imm;
        r_out_ill    <= r_skid_ill;
        r_skid_valid <= 1'b0;
      end else if (w_accept) begin
        // EMPTY -> ONE, or ONE reloaded with no bubble.
        r_out_valid <= 1'b1;
        r_out_imm   <= w_ext_imm;
        r_out_ill   <= w_ext_ill;
      end else begin
        // Data is left in place; only the valid drops.
        r_out_valid <= 1'b0;
      end
    end else if (w_accept) begin
      // Stalled in ONE: park the new item; the output holds steady.
      r_skid_valid <= 1'b1;
      r_skid_imm   <= w_ext_imm;
      r_skid_ill   <= w_ext_ill;
    end
  end

  assign out_valid = r_out_valid;
  assign ImmOp     = r_out_imm;
  assign illegal   = r_out_ill;

endmodule : imm_gen_pipe
`default_nettype wire

// File: tb/tb_imm_gen_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : tb_imm_gen_pipe
//  Description : Self-checking bench for imm_gen_pipe with a 32-bit and a
//                64-bit instance, a reference model and a scoreboard queue
//                per instance.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_imm_gen_pipe;

  localparam int c_WAIT_BOUND = 200;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;

  logic        iv32 = 1'b0, or32 = 1'b0;
  logic        ir32, ov32, ill32;
  logic [31:0] instr32 = '0;
  logic [2:0]  src32 = '0;
  logic [31:0] imm32;

  logic        iv64 = 1'b0, or64 = 1'b0;
  logic        ir64, ov64, ill64;
  logic [31:0] instr64 = '0;
  logic [2:0]  src64 = '0;
  logic [63:0] imm64;

  int n_checks = 0;
  int n_fail   = 0;
  int n_pop32  = 0;
  int n_pop64  = 0;
  bit rnd_on   = 1'b0;

  logic [64:0] q32[$];
  logic [64:0] q64[$];

  always #5 clk = ~clk;

  imm_gen_pipe #(.DATA_WIDTH(32)) dut32 (
    .clk (clk), .rst_n (rst_n),
    .in_valid (iv32), .in_ready (ir32), .instr (instr32), .ImmSrc (src32),
    .out_valid (ov32), .out_ready (or32), .ImmOp (imm32), .illegal (ill32)
  );

  imm_gen_pipe #(.DATA_WIDTH(64)) dut64 (
    .clk (clk), .rst_n (rst_n),
    .in_valid (iv64), .in_ready (ir64), .instr (instr64), .ImmSrc (src64),
    .out_valid (ov64), .out_ready (or64), .ImmOp (imm64), .illegal (ill64)
  );

  task automatic check(input string tag, input logic [64:0] obs, input logic [64:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference model, written from the bit-field definitions with arithmetic
  // shifts. Result is {illegal, imm[63:0]}, truncated to dw.
  function automatic logic [64:0] model(input logic [31:0] ins, input logic [2:0] src, input int dw);
    logic signed [63:0] sx;
    logic signed [63:0] hi;
    logic [63:0]        r;
    logic               ill;
    sx  = {{32{ins[31]}}, ins};
    r   = '0;
    ill = 1'b0;
    case (src)
      3'd0: begin hi = sx >>> 20; r = hi; end
      3'd1: begin hi = sx >>> 25; r = {hi[58:0], 5'b0} | {59'b0, ins[11:7]}; end
      3'd2: begin hi = sx >>> 31; r = {hi[51:0], 12'b0} | (64'(ins[7]) << 11)
                                      | (64'(ins[30:25]) << 5) | (64'(ins[11:8]) << 1); end
      3'd3: r = sx & ~64'hFFF;
      3'd4: begin hi = sx >>> 31; r = {hi[43:0], 20'b0} | (64'(ins[19:12]) << 12)
                                      | (64'(ins[20]) << 11) | (64'(ins[30:21]) << 1); end
      3'd5: r = (64'(ins) >> 20) & ((dw == 64) ? 64'h3F : 64'h1F);
      3'd6: r = (64'(ins) >> 15) & 64'h1F;
      default: ill = 1'b1;
    endcase
    if (dw == 32) r = r & 64'hFFFF_FFFF;
    return {ill, r};
  endfunction

  // Scoreboards: pop on an output transfer, push on an input transfer, both
  // evaluated half a cycle before the edge that performs them.
  always @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q32.delete();
      q64.delete();
    end else begin
      if (ov32 && or32) begin
        check("sb32_nonempty", 65'(q32.size() > 0), 65'd1);
        if (q32.size() > 0) begin
          logic [64:0] e;
          e = q32.pop_front();
          check("sb32_imm", {33'b0, imm32}, {1'b0, 32'b0, e[31:0]});
          check("sb32_ill", 65'(ill32), 65'(e[64]));
        end
        n_pop32++;
      end
      if (iv32 && ir32) q32.push_back(model(instr32, src32, 32));
      if (ov64 && or64) begin
        check("sb64_nonempty", 65'(q64.size() > 0), 65'd1);
        if (q64.size() > 0) begin
          logic [64:0] e;
          e = q64.pop_front();
          check("sb64_imm", {1'b0, imm64}, {1'b0, e[63:0]});
          check("sb64_ill", 65'(ill64), 65'(e[64]));
        end
        n_pop64++;
      end
      if (iv64 && ir64) q64.push_back(model(instr64, src64, 64));
    end
  end

  // Present one item and hold it until accepted; returns 1 time unit after
  // the accepting edge with in_valid already low.
  task automatic send32(input logic [31:0] ins, input logic [2:0] src);
    int waited;
    instr32 = ins; src32 = src; iv32 = 1'b1;
    waited = 0;
    while (!ir32 && waited < c_WAIT_BOUND) begin
      @(posedge clk); #1; waited++;
    end
    if (!ir32) check("send32_in_ready_wait", 65'(ir32), 65'd1);
    else begin @(posedge clk); #1; end
    iv32 = 1'b0;
  endtask

  task automatic send64(input logic [31:0] ins, input logic [2:0] src);
    int waited;
    instr64 = ins; src64 = src; iv64 = 1'b1;
    waited = 0;
    while (!ir64 && waited < c_WAIT_BOUND) begin
      @(posedge clk); #1; waited++;
    end
    if (!ir64) check("send64_in_ready_wait", 65'(ir64), 65'd1);
    else begin @(posedge clk); #1; end
    iv64 = 1'b0;
  endtask

  task automatic drain(input string tag);
    int waited;
    or32 = 1'b1; or64 = 1'b1;
    waited = 0;
    while ((q32.size() != 0 || q64.size() != 0) && waited < c_WAIT_BOUND) begin
      @(posedge clk); #1; waited++;
    end
    check({tag, "_q32_empty"}, 65'(q32.size()), 65'd0);
    check({tag, "_q64_empty"}, 65'(q64.size()), 65'd0);
  endtask

  initial begin
    int pops_before;
    logic [64:0] e_a;

    // Reset state while rst_n is low.
    #12;
    check("rst_out_valid", 65'(ov32), 65'd0);
    check("rst_imm", 65'(imm32), 65'd0);
    check("rst_illegal", 65'(ill32), 65'd0);
    check("rst_in_ready", 65'(ir32), 65'd1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("post_rst_in_ready", 65'(ir32), 65'd1);

    // I-type, 1-cycle latency.
    or32 = 1'b1; or64 = 1'b1;
    send32(32'hFFF0_0093, 3'b000);
    check("i_out_valid", 65'(ov32), 65'd1);
    check("i_imm", 65'(imm32), 65'h0_FFFF_FFFF);
    check("i_illegal", 65'(ill32), 65'd0);
    @(posedge clk); #1;

    // S, J, U back-to-back: one output per cycle, in order.
    send32(32'hFE11_2E23, 3'b001);
    check("b2b_s_valid", 65'(ov32), 65'd1);
    check("b2b_s_imm", 65'(imm32), 65'h0_FFFF_FFFC);
    send32(32'hFF9F_F06F, 3'b100);
    check("b2b_j_valid", 65'(ov32), 65'd1);
    check("b2b_j_imm", 65'(imm32), 65'h0_FFFF_FFF8);
    send32(32'h1234_50B7, 3'b011);
    check("b2b_u_valid", 65'(ov32), 65'd1);
    check("b2b_u_imm", 65'(imm32), 65'h0_1234_5000);
    @(posedge clk); #1;
    check("b2b_idle", 65'(ov32), 65'd0);

    // Backpressure: two fill the buffer, the third waits.
    or32 = 1'b0;
    pops_before = n_pop32;
    e_a = model(32'h8000_0113, 3'b000, 32);
    send32(32'h8000_0113, 3'b000);
    send32(32'h0040_0513, 3'b000);
    check("bp_in_ready_low", 65'(ir32), 65'd0);
    check("bp_hold_first", 65'(imm32), 65'(e_a[31:0]));
    fork
      send32(32'h0010_9193, 3'b101);
    join_none
    repeat (3) begin
      @(posedge clk); #1;
      check("bp_stable_imm", 65'(imm32), 65'(e_a[31:0]));
      check("bp_stable_valid", 65'(ov32), 65'd1);
      check("bp_in_ready_held", 65'(ir32), 65'd0);
    end
    or32 = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    check("bp_count", 65'(n_pop32 - pops_before), 65'd3);
    check("bp_q_empty", 65'(q32.size()), 65'd0);

    // 64-bit instance: illegal code and zimm.
    send64(32'hDEAD_BEEF, 3'b111);
    check("ill64_imm", {1'b0, imm64}, 65'd0);
    check("ill64_flag", 65'(ill64), 65'd1);
    send64(32'h000F_8073, 3'b110);
    check("zimm64_imm", {1'b0, imm64}, 65'h1F);
    check("zimm64_flag", 65'(ill64), 65'd0);
    send64(32'hFFF0_0093, 3'b000);
    check("i64_imm", {1'b0, imm64}, {1'b0, 64'hFFFF_FFFF_FFFF_FFFF});
    send64(32'h0250_1093, 3'b101);
    check("shamt64_imm", {1'b0, imm64}, 65'd37);
    @(posedge clk); #1;
    check("ill64_done", 65'(ov64), 65'd0);

    // Reset mid-operation with the 32-bit buffer full.
    or32 = 1'b0;
    send32(32'h7FF0_0093, 3'b000);
    send32(32'hFE11_2E23, 3'b001);
    check("mid_full", 65'(ir32), 65'd0);
    #3 rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 65'(ov32), 65'd0);
    check("mid_rst_imm", 65'(imm32), 65'd0);
    check("mid_rst_in_ready", 65'(ir32), 65'd1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("mid_post_in_ready", 65'(ir32), 65'd1);
    check("mid_post_valid", 65'(ov32), 65'd0);
    or32 = 1'b1;
    @(posedge clk); #1;

    // Random traffic with random output backpressure on both instances.
    rnd_on = 1'b1;
    fork
      while (rnd_on) begin
        @(posedge clk); #1;
        or32 = ($urandom_range(0, 3) != 0);
        or64 = ($urandom_range(0, 3) != 0);
      end
      begin
        for (int k = 0; k < 1000; k++) begin
          repeat ($urandom_range(0, 1)) begin @(posedge clk); #1; end
          send64($urandom, 3'($urandom_range(0, 7)));
        end
      end
    join_none
    for (int k = 0; k < 10000; k++) begin
      repeat ($urandom_range(0, 1)) begin @(posedge clk); #1; end
      send32($urandom, 3'($urandom_range(0, 7)));
    end
    rnd_on = 1'b0;
    @(posedge clk); #1;
    drain("rnd");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule : tb_imm_gen_pipe
`default_nettype wire
